// File: rtl/dcache_pkg.sv
// Shared types and geometry for the L1 data cache: FSM state, line/word widths,
// and index/tag width helpers derived from the number of lines.
// No logic; imported by dcache_sram and dcache_controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = 3;
    localparam int OFFSET_W   = 5;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return 32 - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Purpose: valid/dirty/tag/data storage for a direct-mapped cache.
// Latency: combinational read of one index; writes land on the rising edge.
// Ports: rd_* read port, line_* refill write (sets valid, clears dirty), word_* store write (sets dirty).
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_W-1:0]     rd_line_o,
    input  logic                  line_we_i,
    input  logic [IDX_W-1:0]      line_idx_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [LINE_W-1:0]     line_dat_i,
    input  logic                  word_we_i,
    input  logic [IDX_W-1:0]      word_idx_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_dat_i
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[line_idx_i] = 1'b1;
            dirty_d[line_idx_i] = 1'b0;
        end
        if (word_we_i) begin
            dirty_d[word_idx_i] = 1'b1;
        end
    end

    // Only the state bits are reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[line_idx_i]  <= line_tag_i;
            data_q[line_idx_i] <= line_dat_i;
        end
        if (word_we_i) begin
            data_q[word_idx_i][word_sel_i*WORD_W +: WORD_W] <= word_dat_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Purpose: direct-mapped write-back/write-allocate L1 D-cache controller; optional
//   hit/miss counters (hit_cnt_o, miss_cnt_o) when DCACHE_STATS_EN is defined.
// Latency: hits complete in the access cycle; a miss stalls through write-back and refill.
// Ports: cpu_* pipeline side (cpu_stall_o freezes the CPU), mem_* line-wide memory side
//   with Moore req/we/addr/data held until a one-cycle mem_ack_i.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W   = idx_width(LINES);
    localparam int TAG_W   = tag_width(LINES);
    localparam int TAG_LSB = OFFSET_W + IDX_W;

    logic [IDX_W-1:0]      cpu_idx;
    logic [TAG_W-1:0]      cpu_tag;
    logic [WORD_SEL_W-1:0] cpu_wsel;
    logic                  unused_addr_bits;

    assign cpu_idx          = cpu_addr_i[TAG_LSB-1:OFFSET_W];
    assign cpu_tag          = cpu_addr_i[31:TAG_LSB];
    assign cpu_wsel         = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;
`ifdef DCACHE_STATS_EN
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
`endif

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              idle, hit, miss, store_hit, refill;

    assign idle      = (state_q == IDLE);
    assign hit       = cpu_req_i && rd_valid && (rd_tag == cpu_tag);
    assign miss      = rst_i && idle && cpu_req_i && !hit;
    // Stores only land in IDLE: a stalled store is re-presented and written on its retry.
    assign store_hit = rst_i && idle && hit && cpu_we_i;
    assign refill    = rst_i && (state_q == ALLOCATE) && mem_ack_i;

    // Outputs are forced quiet for the whole reset cycle, not just after the reset edge.
    assign cpu_stall_o = rst_i && (miss || !idle);
    assign cpu_data_o  = (rst_i && idle && hit && !cpu_we_i) ?
                         rd_line[cpu_wsel*WORD_W +: WORD_W] : 32'd0;
    assign mem_req_o   = rst_i && mem_req_q;
    assign mem_we_o    = rst_i && mem_we_q;
    assign mem_addr_o  = rst_i ? mem_addr_q : 32'd0;
    assign mem_data_o  = rst_i ? mem_data_q : '0;
`ifdef DCACHE_STATS_EN
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
`endif

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (cpu_idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .line_we_i  (refill),
        .line_idx_i (lat_idx_q),
        .line_tag_i (lat_tag_q),
        .line_dat_i (mem_data_i),
        .word_we_i  (store_hit),
        .word_idx_i (cpu_idx),
        .word_sel_i (cpu_wsel),
        .word_dat_i (cpu_data_i)
    );

    always_comb begin
        state_d    = state_q;
        lat_tag_d  = lat_tag_q;
        lat_idx_d  = lat_idx_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef DCACHE_STATS_EN
        hit_cnt_d  = hit_cnt_q + {31'd0, (idle && hit)};
        miss_cnt_d = miss_cnt_q + {31'd0, miss};
`endif
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    lat_tag_d = cpu_tag;
                    lat_idx_d = cpu_idx;
                    mem_req_d = 1'b1;
                    // Victim line is captured now; the array is untouched until refill.
                    if (rd_valid && rd_dirty) begin
                        state_d    = WRITEBACK;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {rd_tag, cpu_idx, {OFFSET_W{1'b0}}};
                        mem_data_d = rd_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
                        mem_data_d = '0;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = ALLOCATE;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {lat_tag_q, lat_idx_q, {OFFSET_W{1'b0}}};
                    mem_data_d = '0;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_addr_d = 32'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                mem_addr_d = 32'd0;
                mem_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            lat_tag_q  <= '0;
            lat_idx_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_data_q <= '0;
`ifdef DCACHE_STATS_EN
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            lat_tag_q  <= lat_tag_d;
            lat_idx_q  <= lat_idx_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef DCACHE_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a behavioural line memory answers requests,
// expected load data goes through a queue, and memory transactions are logged and checked.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk_i = ~clk_i;

    dcache_controller #(.LINES(16), .LINE_W(256)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q [$];
    txn_t         txn_q [$];
    logic [255:0] mem_model [int];

    function automatic logic [31:0] pat_word(input logic [31:0] line_addr, input int w);
        logic [31:0] wv;
        wv = w;
        return {16'hC0DE, line_addr[11:0], wv[3:0]};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        int key;
        key = int'(a >> 5);
        if (mem_model.exists(key)) return mem_model[key];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat_word({a[31:5], 5'b0}, w);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access starting just after a rising edge; services memory while stalled,
    // compares load data against the scoreboard, and returns after the completing edge.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdat, input int lat, output int stalls);
        int          req_cyc;
        logic [31:0] exp;
        req_cyc = 0;
        stalls  = 0;
        txn_q.delete();
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdat;
        #1;
        while (cpu_stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            if (mem_req_o === 1'b1) begin
                req_cyc++;
                if (req_cyc >= lat) begin
                    mem_ack_i = 1'b1;
                    txn_q.push_back('{mem_we_o, mem_addr_o, mem_data_o});
                    if (mem_we_o) mem_model[int'(mem_addr_o >> 5)] = mem_data_o;
                    else          mem_data_i = mem_line(mem_addr_o);
                    req_cyc = 0;
                end
            end
            @(posedge clk_i); #1;
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
            #1;
        end
        chk({tag, "_stall_bound"}, 256'(stalls < 100), 256'(1));
        if (!we && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_data"}, cpu_data_o, exp);
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input int lat, output int stalls);
        exp_q.push_back(exp);
        access(tag, 1'b0, addr, 32'd0, lat, stalls);
    endtask

    initial begin
        int           st;
        int           n;
        logic [255:0] line;
        logic [31:0]  w;

        rst_i      = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h40;
        cpu_data_i = 32'd0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;

        // Reset: outputs quiet even with a request pending.
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        @(posedge clk_i); #1;
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1;

        // Cold load 0x40, ack on the third request cycle.
        line = mem_line(32'h40);
        line[31:0] = 32'hDEAD_BEEF;
        mem_model[int'(32'h40 >> 5)] = line;
        load("cold", 32'h40, 32'hDEAD_BEEF, 3, st);
        chk("cold_stalls", st, 4);
        chk("cold_ntxn", txn_q.size(), 1);
        if (txn_q.size() > 0) begin
            chk("cold_we", txn_q[0].we, 0);
            chk("cold_addr", txn_q[0].addr, 32'h40);
        end
        #1;
        chk("cold_no_second_req", mem_req_o, 0);
        chk("idle_data_zero", cpu_data_o, 0);

        // Store hit then load of the same word.
        access("st_hit", 1'b1, 32'h44, 32'h1234_5678, 3, st);
        chk("st_hit_stalls", st, 0);
        chk("st_hit_ntxn", txn_q.size(), 0);
        load("ld_hit", 32'h44, 32'h1234_5678, 3, st);
        chk("ld_hit_stalls", st, 0);
        chk("ld_hit_ntxn", txn_q.size(), 0);

        // Dirty eviction: same index, new tag.
        load("evict", 32'h244, pat_word(32'h240, 1), 3, st);
        chk("evict_ntxn", txn_q.size(), 2);
        if (txn_q.size() == 2) begin
            line = mem_line(32'h40);
            line[63:32] = 32'h1234_5678;
            chk("evict_wb_we", txn_q[0].we, 1);
            chk("evict_wb_addr", txn_q[0].addr, 32'h40);
            chk("evict_wb_data", txn_q[0].data, line);
            chk("evict_rd_we", txn_q[1].we, 0);
            chk("evict_rd_addr", txn_q[1].addr, 32'h240);
        end

        // Store miss: clean refill then store on retry, proven dirty by a later eviction.
        access("st_miss", 1'b1, 32'h80, 32'hA5A5_A5A5, 2, st);
        chk("st_miss_stalls", st, 3);
        chk("st_miss_ntxn", txn_q.size(), 1);
        if (txn_q.size() > 0) chk("st_miss_rd_addr", txn_q[0].addr, 32'h80);
        load("st_miss_rb", 32'h80, 32'hA5A5_A5A5, 2, st);
        chk("st_miss_rb_stalls", st, 0);
        load("evict2", 32'h280, pat_word(32'h280, 0), 2, st);
        chk("evict2_ntxn", txn_q.size(), 2);
        if (txn_q.size() == 2) begin
            line = '0;
            for (int i = 0; i < 8; i++) line[i*32 +: 32] = pat_word(32'h80, i);
            line[31:0] = 32'hA5A5_A5A5;
            chk("evict2_wb_addr", txn_q[0].addr, 32'h80);
            chk("evict2_wb_data", txn_q[0].data, line);
        end

        // Reset in the middle of ALLOCATE.
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h100;
        n = 0;
        #1;
        while (!(mem_req_o === 1'b1 && mem_we_o === 1'b0) && n < 20) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("alloc_seen_bound", 256'(n < 20), 256'(1));
        rst_i = 1'b0;
        @(posedge clk_i); #2;
        chk("midrst_mem_req", mem_req_o, 0);
        chk("midrst_stall", cpu_stall_o, 0);
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        chk("postrst_mem_req", mem_req_o, 0);
        chk("postrst_stall", cpu_stall_o, 0);
        @(posedge clk_i); #1;

        // Same address misses again; ack in the very cycle the request rises.
        load("remiss", 32'h100, pat_word(32'h100, 0), 1, st);
        chk("remiss_stalls", st, 2);
        chk("remiss_ntxn", txn_q.size(), 1);
        if (txn_q.size() > 0) chk("remiss_addr", txn_q[0].addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            w = 32'h100 + 32'(i * 4);
            load("hit_run", w, pat_word(32'h100, i), 1, st);
            chk("hit_run_stalls", st, 0);
        end
`ifdef DCACHE_STATS_EN
        chk("stats_miss", miss_cnt, 1);
        chk("stats_hit", hit_cnt, 4);
`endif

        // Stray ack with no request outstanding must be ignored.
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        chk("stray_ack_req", mem_req_o, 0);
        load("stray_ack_hit", 32'h104, pat_word(32'h100, 1), 1, st);
        chk("stray_ack_stalls", st, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

L1 data cache controller between the CPU's MEM stage and the off-chip data memory. Direct-mapped, write-back, write-allocate; one 32-bit word per CPU access, 256-bit lines to memory. Hits complete in the access cycle. Misses stall the pipeline via `cpu_stall_o` while the FSM writes back a dirty victim and refills the line.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of 2, ≥2.
- `LINE_W`, 256: line width in bits; fixed at 8 words.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `cpu_req_i`  in  1  CPU access valid (MemRead or MemWrite).
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address; word aligned.
- `cpu_data_i`  in  32  store data.
- `cpu_data_o`  out  32  load data; valid when `cpu_req_i && !cpu_we_i && !cpu_stall_o`.
- `cpu_stall_o`  out  1  freeze pipeline; CPU holds its request stable while this is high.
- `mem_req_o`  out  1  memory transaction request.
- `mem_we_o`  out  1  1 = line write-back, 0 = line read.
- `mem_addr_o`  out  32  line address; bits [4:0] always 0.
- `mem_data_o`  out  256  write-back line.
- `mem_data_i`  in  256  refill line; sampled on `mem_ack_i`.
- `mem_ack_i`  in  1  one-cycle completion pulse.

## Operation
- Address split: offset [4:0], word select [4:2], index [4+log2(LINES):5], tag = remaining upper bits. With 16 lines: index [8:5], tag [31:9], 23 bits.
- Per-line state: valid, dirty, tag, 256-bit data.
- Hit = `cpu_req_i && valid[idx] && tag[idx]==addr tag`.
- Load hit: `cpu_data_o` = selected word, combinational.
- Store hit: the word is written at the clock edge and dirty is set.
- No request: `cpu_data_o` = 0, no state change.
- FSM states:
  - IDLE: on a miss, latch the address and go to WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - WRITEBACK: `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, idx, 5'b0}, `mem_data_o`=victim line. On `mem_ack_i`, go to ALLOCATE.
  - ALLOCATE: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={latched tag, idx, 5'b0}. On `mem_ack_i`, write `mem_data_i` into the line, set valid, clear dirty, set the tag, go to IDLE.
- Stall rule: `cpu_stall_o` = (IDLE && `cpu_req_i` && miss) || state≠IDLE.
- A store miss completes as a store hit in the first IDLE cycle after refill. The CPU re-presents it because it is stalled.
- Memory protocol: `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_data_o` are Moore outputs, held stable until `mem_ack_i`. Each ack completes exactly one transaction.
- `mem_req_o` still high the cycle after an ack (WRITEBACK→ALLOCATE) is a new transaction.
- `mem_ack_i` while `mem_req_o`=0 is ignored.

## Timing
- Reset (`rst_i`=0 at an edge): state to IDLE, all valid/dirty cleared, latched address cleared.
  - Outputs while in reset: `cpu_stall_o`=0, `cpu_data_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - Tag and data arrays are not reset.
  - Reset mid-miss abandons the transaction; the dirty victim is lost by definition.
- Hit latency: 0 (same cycle); store visible to a load on the next cycle.
- Clean miss:
  - Miss seen in cycle 0; `mem_req_o` rises in cycle 1.
  - If ack arrives in cycle k, the line is written at the end of k.
  - Cycle k+1 is IDLE with a hit; stall drops and data is valid.
- Dirty miss: write-back ack in cycle j; the read request is issued in cycle j+1.
- `cpu_req_i` dropping or the address changing mid-miss: the refill of the latched address still completes; no new miss is accepted until IDLE.
- Ack in the same cycle `mem_req_o` first rises is legal and accepted.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_cnt_o[31:0]` and `miss_cnt_o[31:0]`.
  - Counters increment once per IDLE-cycle access: `hit_cnt_o` on a hit, `miss_cnt_o` on a miss-detect cycle.
  - Retried accesses after refill count as hits.
  - Counters wrap at 2^32 and reset to 0.
- Macro undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `dcache_pkg`: state enum (IDLE, WRITEBACK, ALLOCATE), `LINE_W`, `WORD_SEL_W`=3, offset width 5, and tag/index width functions of `LINES`.
- Sub-module `dcache_sram`: tag/valid/dirty/data arrays.
  - Combinational read of one index.
  - Synchronous write with two modes: full-line write (refill) and single-word write with dirty set.
  - Valid/dirty clear on reset.
- The controller holds the FSM, address latch, hit logic and word mux.

## Test plan
- Cold load 0x0000_0040, memory acks 3 cycles after request with line word0=0xDEAD_BEEF → stall 4 cycles, then `cpu_data_o`=0xDEAD_BEEF with no second memory request.
- Store 0x1234_5678 to 0x44 (hit), then load 0x44 → no stall, load returns 0x1234_5678, no memory traffic.
- Dirty eviction: after the above, load 0x244 (same index 2, new tag) → write-back with `mem_addr_o`=0x40 and word1=0x1234_5678, then read with `mem_addr_o`=0x240, then hit.
- Store miss to 0x80 with data 0xA5A5_A5A5 → clean refill, store applied on the retry cycle, dirty set; an evicting load then writes back 0xA5A5_A5A5 at word 0.
- Reset asserted during ALLOCATE → the next cycle has `mem_req_o`=0 and `cpu_stall_o`=0, and a load to the previous address misses again.
- With `DCACHE_STATS_EN`: 1 miss + 3 hits → `miss_cnt_o`=1, `hit_cnt_o`=4 (the retry counts as a hit).
